// File: rtl/stack_pointer_unit.sv
// ESP/EBP stack-pointer unit: write/push/pop, two-step ENTER/LEAVE, stack strobes.
// Optional stack limit checker enabled by defining STACK_LIMIT_CHECK_EN.
module stack_pointer_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter logic [31:0] RESET_ESP   = 32'h000fffff,
    parameter logic [31:0] RESET_EBP   = 32'h000fffff,
    parameter int unsigned STEP        = 4,
    parameter logic [31:0] STACK_LIMIT = 32'h000f0000,
    parameter int unsigned FRAME_W     = 16
) (
    input  logic               clk1,
    input  logic               reset,
    input  logic [3:0]         op,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [WIDTH-1:0]   write_data,
    input  logic [FRAME_W-1:0] frame_size,
    input  logic [WIDTH-1:0]   mem_rdata,
    input  logic               mem_rvalid,
    output logic [WIDTH-1:0]   esp,
    output logic [WIDTH-1:0]   ebp,
    output logic [WIDTH-1:0]   mem_addr,
    output logic               mem_push,
    output logic               mem_pop,
    output logic               fault
);

    localparam logic [WIDTH-1:0] RST_ESP_W = WIDTH'(RESET_ESP);
    localparam logic [WIDTH-1:0] RST_EBP_W = WIDTH'(RESET_EBP);
    localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] LIMIT_W   = WIDTH'(STACK_LIMIT);

`ifdef STACK_LIMIT_CHECK_EN
    localparam bit LIMIT_CHECK = 1'b1;
`else
    localparam bit LIMIT_CHECK = 1'b0;
`endif

    localparam logic [3:0] OP_WRITE_ESP = 4'd2;
    localparam logic [3:0] OP_WRITE_EBP = 4'd3;
    localparam logic [3:0] OP_PUSH      = 4'd4;
    localparam logic [3:0] OP_POP       = 4'd5;
    localparam logic [3:0] OP_ENTER     = 4'd6;
    localparam logic [3:0] OP_LEAVE     = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ENTER_SET  = 2'd1,
        ST_LEAVE_POP  = 2'd2,
        ST_LEAVE_WAIT = 2'd3
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [WIDTH-1:0]   esp_r, esp_nxt_s;
    logic [WIDTH-1:0]   ebp_r, ebp_nxt_s;
    logic [WIDTH-1:0]   addr_r, addr_nxt_s;
    logic               push_r, push_nxt_s;
    logic               pop_r, pop_nxt_s;
    logic               fault_r, fault_nxt_s;
    logic [FRAME_W-1:0] frame_r, frame_nxt_s;

    logic               accept_s;
    logic               viol_s;
    logic               push_viol_s, enter_viol_s, pop_viol_s;
    logic [WIDTH:0]     dec1_s, dec2_s, inc1_s;

    assign accept_s = op_valid && (state_r == ST_IDLE);
    assign op_ready = (state_r == ST_IDLE);

    // Extra top bit of each sum/difference is the borrow or carry out.
    assign dec1_s = {1'b0, esp_r} - {1'b0, STEP_W};
    assign dec2_s = {1'b0, dec1_s[WIDTH-1:0]} - {1'b0, WIDTH'(frame_size)};
    assign inc1_s = {1'b0, esp_r} + {1'b0, STEP_W};

    assign push_viol_s  = dec1_s[WIDTH] || (dec1_s[WIDTH-1:0] < LIMIT_W);
    assign enter_viol_s = push_viol_s || dec2_s[WIDTH] || (dec2_s[WIDTH-1:0] < LIMIT_W);
    assign pop_viol_s   = inc1_s[WIDTH] || (inc1_s[WIDTH-1:0] > RST_ESP_W);

    // Limit violation for the op currently offered
    always_comb begin
        viol_s = 1'b0;
        case (op)
            OP_PUSH:  viol_s = LIMIT_CHECK && push_viol_s;
            OP_ENTER: viol_s = LIMIT_CHECK && enter_viol_s;
            OP_POP:   viol_s = LIMIT_CHECK && pop_viol_s;
            default:  viol_s = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk1) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !viol_s) begin
                    case (op)
                        OP_ENTER: state_nxt_s = ST_ENTER_SET;
                        OP_LEAVE: state_nxt_s = ST_LEAVE_POP;
                        default:  state_nxt_s = ST_IDLE;
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ENTER_SET: state_nxt_s = ST_IDLE;
            ST_LEAVE_POP: state_nxt_s = ST_LEAVE_WAIT;
            ST_LEAVE_WAIT: begin
                if (mem_rvalid) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LEAVE_WAIT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output/datapath next values; strobes default low every cycle
    always_comb begin
        esp_nxt_s   = esp_r;
        ebp_nxt_s   = ebp_r;
        addr_nxt_s  = addr_r;
        frame_nxt_s = frame_r;
        push_nxt_s  = 1'b0;
        pop_nxt_s   = 1'b0;
        fault_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && viol_s) begin
                    fault_nxt_s = 1'b1;
                end else if (accept_s) begin
                    case (op)
                        OP_WRITE_ESP: esp_nxt_s = write_data;
                        OP_WRITE_EBP: ebp_nxt_s = write_data;
                        OP_PUSH: begin
                            esp_nxt_s  = dec1_s[WIDTH-1:0];
                            addr_nxt_s = dec1_s[WIDTH-1:0];
                            push_nxt_s = 1'b1;
                        end
                        OP_POP: begin
                            addr_nxt_s = esp_r;
                            pop_nxt_s  = 1'b1;
                            esp_nxt_s  = inc1_s[WIDTH-1:0];
                        end
                        OP_ENTER: begin
                            esp_nxt_s   = dec1_s[WIDTH-1:0];
                            addr_nxt_s  = dec1_s[WIDTH-1:0];
                            push_nxt_s  = 1'b1;
                            frame_nxt_s = frame_size;
                        end
                        OP_LEAVE: esp_nxt_s = ebp_r;
                        default:  esp_nxt_s = esp_r;
                    endcase
                end else begin
                    esp_nxt_s = esp_r;
                end
            end
            ST_ENTER_SET: begin
                ebp_nxt_s = esp_r;
                esp_nxt_s = esp_r - WIDTH'(frame_r);
            end
            ST_LEAVE_POP: begin
                addr_nxt_s = esp_r;
                pop_nxt_s  = 1'b1;
                esp_nxt_s  = inc1_s[WIDTH-1:0];
            end
            ST_LEAVE_WAIT: begin
                if (mem_rvalid) begin
                    ebp_nxt_s = mem_rdata;
                end else begin
                    ebp_nxt_s = ebp_r;
                end
            end
            default: esp_nxt_s = esp_r;
        endcase
    end

    // Datapath and strobe registers
    always_ff @(posedge clk1) begin
        if (reset) begin
            esp_r   <= RST_ESP_W;
            ebp_r   <= RST_EBP_W;
            addr_r  <= {WIDTH{1'b0}};
            frame_r <= {FRAME_W{1'b0}};
            push_r  <= 1'b0;
            pop_r   <= 1'b0;
            fault_r <= 1'b0;
        end else begin
            esp_r   <= esp_nxt_s;
            ebp_r   <= ebp_nxt_s;
            addr_r  <= addr_nxt_s;
            frame_r <= frame_nxt_s;
            push_r  <= push_nxt_s;
            pop_r   <= pop_nxt_s;
            fault_r <= fault_nxt_s;
        end
    end

    assign esp      = esp_r;
    assign ebp      = ebp_r;
    assign mem_addr = addr_r;
    assign mem_push = push_r;
    assign mem_pop  = pop_r;
    assign fault    = fault_r;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Self-checking bench for stack_pointer_unit: directed scenarios plus random ops
// checked against an arithmetic reference model of ESP/EBP/stack address.
module tb_stack_pointer_unit;

    localparam logic [31:0] TOP   = 32'h000fffff;
    localparam logic [31:0] LIMIT = 32'h000f0000;

    logic        clk1 = 1'b0;
    logic        reset;
    logic [3:0]  op;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] write_data;
    logic [15:0] frame_size;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic [31:0] esp;
    logic [31:0] ebp;
    logic [31:0] mem_addr;
    logic        mem_push;
    logic        mem_pop;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_esp, m_ebp, m_addr;

    stack_pointer_unit dut (
        .clk1       (clk1),
        .reset      (reset),
        .op         (op),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .write_data (write_data),
        .frame_size (frame_size),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .esp        (esp),
        .ebp        (ebp),
        .mem_addr   (mem_addr),
        .mem_push   (mem_push),
        .mem_pop    (mem_pop),
        .fault      (fault)
    );

    always #5 clk1 = ~clk1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic p, input logic q,
                               input logic f, input logic rdy);
        check({tag, ".esp"}, esp, m_esp);
        check({tag, ".ebp"}, ebp, m_ebp);
        check({tag, ".addr"}, mem_addr, m_addr);
        check({tag, ".push"}, {31'd0, mem_push}, {31'd0, p});
        check({tag, ".pop"}, {31'd0, mem_pop}, {31'd0, q});
        check({tag, ".fault"}, {31'd0, fault}, {31'd0, f});
        check({tag, ".ready"}, {31'd0, op_ready}, {31'd0, rdy});
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic model_reset();
        m_esp  = TOP;
        m_ebp  = TOP;
        m_addr = 32'h0;
    endtask

    function automatic bit model_viol(input logic [3:0] o, input logic [31:0] e32,
                                      input logic [15:0] fs);
        longint e, f, lim, top;
        bit v;
        e   = longint'(e32);
        f   = longint'(fs);
        lim = longint'(LIMIT);
        top = longint'(TOP);
        v   = 1'b0;
`ifdef STACK_LIMIT_CHECK_EN
        case (o)
            4'd4:    v = (e - 64'sd4 < lim);
            4'd6:    v = (e - 64'sd4 - f < lim);
            4'd5:    v = (e + 64'sd4 > top);
            default: v = 1'b0;
        endcase
`else
        v = (o == 4'd15) && (e < lim) && (f > top) && 1'b0;
`endif
        return v;
    endfunction

    // Offer one op while idle and check every cycle until it completes.
    task automatic do_op(input string tag, input logic [3:0] o, input logic [31:0] wd,
                         input logic [15:0] fs, input logic [31:0] rd, input int dly);
        op         = o;
        write_data = wd;
        frame_size = fs;
        op_valid   = 1'b1;
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
        check({tag, ".ready_in"}, {31'd0, op_ready}, 32'd1);
        if (model_viol(o, m_esp, fs)) begin
            tick();
            op_valid = 1'b0;
            check_state({tag, ".fault"}, 1'b0, 1'b0, 1'b1, 1'b1);
        end else begin
            tick();
            op_valid = 1'b0;
            case (o)
                4'd2: begin
                    m_esp = wd;
                    check_state({tag, ".wesp"}, 1'b0, 1'b0, 1'b0, 1'b1);
                end
                4'd3: begin
                    m_ebp = wd;
                    check_state({tag, ".webp"}, 1'b0, 1'b0, 1'b0, 1'b1);
                end
                4'd4: begin
                    m_esp  = m_esp - 32'd4;
                    m_addr = m_esp;
                    check_state({tag, ".push"}, 1'b1, 1'b0, 1'b0, 1'b1);
                end
                4'd5: begin
                    m_addr = m_esp;
                    m_esp  = m_esp + 32'd4;
                    check_state({tag, ".pop"}, 1'b0, 1'b1, 1'b0, 1'b1);
                end
                4'd6: begin
                    m_esp  = m_esp - 32'd4;
                    m_addr = m_esp;
                    check_state({tag, ".enter1"}, 1'b1, 1'b0, 1'b0, 1'b0);
                    tick();
                    m_ebp = m_esp;
                    m_esp = m_esp - {16'd0, fs};
                    check_state({tag, ".enter2"}, 1'b0, 1'b0, 1'b0, 1'b1);
                end
                4'd7: begin
                    m_esp = m_ebp;
                    check_state({tag, ".leave1"}, 1'b0, 1'b0, 1'b0, 1'b0);
                    tick();
                    m_addr = m_esp;
                    m_esp  = m_esp + 32'd4;
                    check_state({tag, ".leave2"}, 1'b0, 1'b1, 1'b0, 1'b0);
                    mem_rvalid = 1'b0;
                    for (int i = 0; i < dly; i++) begin
                        tick();
                        check_state({tag, ".lwait"}, 1'b0, 1'b0, 1'b0, 1'b0);
                    end
                    mem_rvalid = 1'b1;
                    mem_rdata  = rd;
                    tick();
                    m_ebp = rd;
                    check_state({tag, ".leave3"}, 1'b0, 1'b0, 1'b0, 1'b1);
                end
                default: check_state({tag, ".nop"}, 1'b0, 1'b0, 1'b0, 1'b1);
            endcase
        end
        mem_rvalid = 1'b0;
    endtask

    initial begin
        logic [3:0]  r_op;
        logic [31:0] r_wd;
        int          guard;

        reset      = 1'b1;
        op         = 4'd0;
        op_valid   = 1'b0;
        write_data = 32'h0;
        frame_size = 16'h0;
        mem_rdata  = 32'h0;
        mem_rvalid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
        check_state("reset", 1'b0, 1'b0, 1'b0, 1'b1);
        check("reset.esp_const", esp, 32'h000fffff);
        tick();
        check_state("idle", 1'b0, 1'b0, 1'b0, 1'b1);

`ifndef STACK_LIMIT_CHECK_EN
        // Push/pop round trip with one-cycle strobes
        do_op("wr", 4'd2, 32'h00001000, 16'h0, 32'h0, 0);
        do_op("push", 4'd4, 32'h0, 16'h0, 32'h0, 0);
        check("push.addr_const", mem_addr, 32'h00000ffc);
        tick();
        check_state("push.after", 1'b0, 1'b0, 1'b0, 1'b1);
        do_op("pop", 4'd5, 32'h0, 16'h0, 32'h0, 0);
        check("pop.esp_const", esp, 32'h00001000);

        // ENTER with a 0x20 frame
        do_op("webp", 4'd3, 32'h00002000, 16'h0, 32'h0, 0);
        do_op("enter", 4'd6, 32'h0, 16'h0020, 32'h0, 0);
        check("enter.esp_const", esp, 32'h00000fdc);
        check("enter.ebp_const", ebp, 32'h00000ffc);

        // LEAVE with a PUSH held valid while busy
        op       = 4'd7;
        op_valid = 1'b1;
        tick();
        op    = 4'd4;
        m_esp = m_ebp;
        check_state("hold.l1", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        m_addr = m_esp;
        m_esp  = m_esp + 32'd4;
        check_state("hold.l2", 1'b0, 1'b1, 1'b0, 1'b0);
        check("hold.addr_const", mem_addr, 32'h00000ffc);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_state("hold.wait", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h00002000;
        tick();
        mem_rvalid = 1'b0;
        m_ebp      = 32'h00002000;
        check_state("hold.l3", 1'b0, 1'b0, 1'b0, 1'b1);
        check("hold.esp_const", esp, 32'h00001000);
        tick();
        op_valid = 1'b0;
        m_esp    = m_esp - 32'd4;
        m_addr   = m_esp;
        check_state("hold.push", 1'b1, 1'b0, 1'b0, 1'b1);

        // Pointer wrap below zero
        do_op("wr0", 4'd2, 32'h0, 16'h0, 32'h0, 0);
        do_op("wrap", 4'd4, 32'h0, 16'h0, 32'h0, 0);
        check("wrap.esp_const", esp, 32'hfffffffc);
`else
        // Limit check: push just above the limit faults and changes nothing
        do_op("wrl", 4'd2, 32'h000f0002, 16'h0, 32'h0, 0);
        do_op("lim", 4'd4, 32'h0, 16'h0, 32'h0, 0);
        check("lim.esp_const", esp, 32'h000f0002);
        check("lim.fault_const", {31'd0, fault}, 32'd1);
`endif

        // Reset while waiting for LEAVE data
        do_op("webp2", 4'd3, 32'h000f3000, 16'h0, 32'h0, 0);
        op       = 4'd7;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        check_state("rstw", 1'b0, 1'b0, 1'b0, 1'b1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hdeadbeef;
        tick();
        mem_rvalid = 1'b0;
        check_state("rstw.rvalid", 1'b0, 1'b0, 1'b0, 1'b1);
        guard = 0;
        while (!op_ready && guard < 10) begin
            tick();
            guard++;
        end

        // Random ops against the reference model
        for (int n = 0; n < 300; n++) begin
            r_op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                r_wd = 32'h000f8000 + ($urandom & 32'h00007ffc);
            end else begin
                r_wd = $urandom;
            end
            do_op("rnd", r_op, r_wd, 16'($urandom_range(0, 16'h0400)), $urandom,
                  int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_pointer_unit.md
Name: stack_pointer_unit

Overview:
Parametrised ESP/EBP stack-pointer unit for the CPU core; successor to the single ESP register. Holds ESP and EBP, executes write/push/pop plus two-step ENTER/LEAVE frame sequences, and issues stack memory address strobes to the memory stage. Ops enter through a valid/ready handshake. An optional limit checker raises a fault on stack overflow or underflow.

Parameters:
WIDTH, 32, pointer width in bits
RESET_ESP, 32'h000fffff, ESP value after reset (top of stack), truncated to WIDTH
RESET_EBP, 32'h000fffff, EBP value after reset, truncated to WIDTH
STEP, 4, bytes per push/pop
STACK_LIMIT, 32'h000f0000, lowest legal ESP (limit check only)
FRAME_W, 16, width of the ENTER frame size

Ports:
clk1  in  1  clock, all state changes on rising edge
reset  in  1  synchronous, active-high reset
op  in  4  0 NOP, 1 READ, 2 WRITE_ESP, 3 WRITE_EBP, 4 PUSH, 5 POP, 6 ENTER, 7 LEAVE; 8-F treated as NOP
op_valid  in  1  op present
op_ready  out  1  unit idle; op accepted when op_valid && op_ready
write_data  in  WIDTH  data for WRITE_ESP/WRITE_EBP
frame_size  in  FRAME_W  ENTER local-area size in bytes, sampled at accept
mem_rdata  in  WIDTH  popped word for LEAVE
mem_rvalid  in  1  mem_rdata valid
esp  out  WIDTH  current ESP
ebp  out  WIDTH  current EBP
mem_addr  out  WIDTH  stack access address (registered)
mem_push  out  1  one-cycle write strobe at mem_addr
mem_pop  out  1  one-cycle read strobe at mem_addr
fault  out  1  one-cycle limit-violation pulse

Behaviour:
- Reset (synchronous, priority over everything): esp=RESET_ESP, ebp=RESET_EBP, mem_addr=0, mem_push=0, mem_pop=0, fault=0, state IDLE. Reset mid-sequence aborts ENTER/LEAVE with no further strobes.
- States: IDLE, ENTER_SET, LEAVE_POP, LEAVE_WAIT. op_ready=1 only in IDLE, combinational from state.
- mem_push, mem_pop and fault default to 0 each cycle; they are single-cycle pulses.
- Single-cycle ops, on the accept edge:
  - NOP/READ: no change.
  - WRITE_ESP: esp<=write_data.
  - WRITE_EBP: ebp<=write_data.
  - PUSH: esp<=esp-STEP, mem_addr<=esp-STEP, mem_push<=1.
  - POP: mem_addr<=esp, mem_pop<=1, esp<=esp+STEP.
- ENTER:
  - Accept edge: esp<=esp-STEP, mem_addr<=esp-STEP, mem_push<=1 (caller drives ebp as the write data), latch frame_size, go to ENTER_SET.
  - Next edge: ebp<=esp, esp<=esp-frame_size (zero-extended), go to IDLE.
  - Total latency: 2 cycles.
- LEAVE:
  - Accept edge: esp<=ebp, go to LEAVE_POP.
  - Next edge: mem_addr<=esp, mem_pop<=1, esp<=esp+STEP, go to LEAVE_WAIT.
  - In LEAVE_WAIT: on the first edge with mem_rvalid=1, ebp<=mem_rdata, go to IDLE.
  - mem_rvalid is ignored in all other states.
  - No timeout; only reset exits LEAVE_WAIT.
- Arithmetic: all pointer math is WIDTH-bit unsigned, modulo 2^WIDTH.
- While busy: op_valid is ignored; the op is not lost, the caller holds it until op_ready.

Optional Feature:
Macro STACK_LIMIT_CHECK_EN.
- Defined, checks at accept:
  - PUSH or ENTER with esp-STEP < STACK_LIMIT, or ENTER with esp-STEP-frame_size < STACK_LIMIT, or any borrow: op is consumed with no register or strobe change, fault=1 for one cycle.
  - POP with esp+STEP > RESET_ESP, or carry: same fault behaviour.
  - LEAVE is not checked.
- Undefined: no checks, pointers wrap, fault tied to 0.

Test Plan:
- Reset then idle → esp=0x000fffff, ebp=0x000fffff, op_ready=1, all strobes 0.
- WRITE_ESP 0x00001000, then PUSH → esp=0x00000ffc, mem_addr=0x00000ffc, mem_push high exactly 1 cycle. Then POP → mem_addr=0x00000ffc, mem_pop pulse, esp=0x00001000.
- esp=0x1000, ebp=0x2000, ENTER frame_size=0x20 → cycle 1: mem_addr=0xffc, mem_push. Cycle 2: ebp=0xffc, esp=0xfdc. op_ready low for exactly 1 cycle.
- From that state, LEAVE, mem_rvalid asserted 3 cycles after the pop strobe with mem_rdata=0x2000 → mem_pop at addr 0xffc, esp=0x1000, ebp=0x2000, op_ready returns the cycle after mem_rvalid. A PUSH held valid while busy executes only after op_ready=1.
- Reset asserted in LEAVE_WAIT → reset values, IDLE, a later mem_rvalid is ignored.
- STACK_LIMIT_CHECK_EN with esp=0x000f0002, PUSH → fault pulse, esp unchanged, no mem_push. Without the macro, esp=0x0 then PUSH → esp=0xfffffffc.
